// File: rtl/d_mem_ctrl.sv
// d_mem_ctrl: multi-cycle data memory responder for the load/store path.
// One request is accepted from IDLE. After WAIT_CYCLES wait states the access
// is performed on the internal word array, and ready is strobed for one cycle.
// Optional feature macro: D_MEM_SUBWORD_EN enables byte/halfword accesses.
// When it is not defined, every access is a 32-bit word access.
module d_mem_ctrl #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        misaligned
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0]  CNT_INIT  = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      r_state, w_next;
    logic [3:0]  r_cnt, w_cnt_next;

    // Captured request.
    logic           r_we;
    logic [AW+1:0]  r_addr;
    logic [31:0]    r_wdata;
`ifdef D_MEM_SUBWORD_EN
    logic [1:0]     r_size;
    logic           r_sext;
`endif

    // Registered response.
    logic        r_ready;
    logic [31:0] r_rdata;
    logic        r_mis;

    logic [31:0] r_mem [DEPTH_WORDS];

    // Operation actually being committed.
    logic           w_in_idle;
    logic           w_commit;
    logic           w_we;
    logic [AW+1:0]  w_addr;
    logic [31:0]    w_wdata;
    logic           w_sext;
    logic           w_is_byte, w_is_half, w_is_word;
    logic           w_mis;
    logic [AW-1:0]  w_idx;
    logic [31:0]    w_rword;
    logic [31:0]    w_shift;
    logic [31:0]    w_load;
    logic [31:0]    w_repl;
    logic [3:0]     w_lane_en;
    logic [31:0]    w_wr_word;
    logic           w_unused_ok;

    assign w_in_idle = (r_state == ST_IDLE);

    // With zero wait states the access happens at the accept edge, so the
    // live inputs are used there instead of the (not yet loaded) captures.
    assign w_commit = (w_in_idle && req && ZERO_WAIT) ||
                      ((r_state == ST_WAIT) && (r_cnt == '0));

    assign w_we    = w_in_idle ? we              : r_we;
    assign w_addr  = w_in_idle ? addr[AW+1:0]    : r_addr;
    assign w_wdata = w_in_idle ? wdata           : r_wdata;

`ifdef D_MEM_SUBWORD_EN
    logic [1:0] w_size;
    assign w_size    = w_in_idle ? size     : r_size;
    assign w_sext    = w_in_idle ? sign_ext : r_sext;
    assign w_is_byte = (w_size == 2'b00);
    assign w_is_half = (w_size == 2'b01);
    assign w_unused_ok = ^addr[31:AW+2];
`else
    assign w_sext    = 1'b0;
    assign w_is_byte = 1'b0;
    assign w_is_half = 1'b0;
    assign w_unused_ok = ^{addr[31:AW+2], size, sign_ext};
`endif
    assign w_is_word = !w_is_byte && !w_is_half;

    assign w_mis = (w_is_half && w_addr[0]) ||
                   (w_is_word && (w_addr[1:0] != 2'b00));

    assign w_idx   = w_addr[AW+1:2];
    assign w_rword = r_mem[w_idx];

    // Aligned halves have addr[0]=0, so one byte-granular shift serves both.
    assign w_shift = w_rword >> {w_addr[1:0], 3'b000};

    // Load extraction and extension.
    always_comb begin
        w_load = w_rword;
        if (w_is_byte) begin
            w_load = {{24{w_sext & w_shift[7]}}, w_shift[7:0]};
        end else if (w_is_half) begin
            w_load = {{16{w_sext & w_shift[15]}}, w_shift[15:0]};
        end
    end

    // Store lane enables and merged write word.
    always_comb begin
        w_lane_en = '0;
        w_repl    = w_wdata;
        w_wr_word = w_rword;
        if (w_is_byte) begin
            w_lane_en[w_addr[1:0]] = 1'b1;
            w_repl = {4{w_wdata[7:0]}};
        end else if (w_is_half) begin
            w_lane_en[{w_addr[1], 1'b0}] = 1'b1;
            w_lane_en[{w_addr[1], 1'b1}] = 1'b1;
            w_repl = {2{w_wdata[15:0]}};
        end else begin
            w_lane_en = '1;
        end
        for (int unsigned i = 0; i < 4; i++) begin
            if (w_lane_en[i]) begin
                w_wr_word[i*8 +: 8] = w_repl[i*8 +: 8];
            end
        end
    end

    // State register and wait counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    if (ZERO_WAIT) begin
                        w_next = ST_RESP;
                    end else begin
                        w_next     = ST_WAIT;
                        w_cnt_next = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_next = ST_RESP;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Request capture at the accept edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
`ifdef D_MEM_SUBWORD_EN
            r_size  <= '0;
            r_sext  <= 1'b0;
`endif
        end else if (w_in_idle && req) begin
            r_we    <= we;
            r_addr  <= addr[AW+1:0];
            r_wdata <= wdata;
`ifdef D_MEM_SUBWORD_EN
            r_size  <= size;
            r_sext  <= sign_ext;
`endif
        end
    end

    // Response registers: loaded at the commit edge, cleared otherwise.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
            r_mis   <= 1'b0;
        end else begin
            r_ready <= w_commit;
            r_mis   <= w_commit && w_mis;
            r_rdata <= (w_commit && !w_we && !w_mis) ? w_load : '0;
        end
    end

    // Word array write; contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (w_commit && w_we && !w_mis) begin
            r_mem[w_idx] <= w_wr_word;
        end
    end

    assign ready      = r_ready;
    assign rdata      = r_rdata;
    assign misaligned = r_mis;

endmodule
